hangy_player: RTL

- Host-side driver for the hangy game core. It turns a guess handshake into the core's chip_input strobe protocol, then decodes chip_output into per-guess results.
- Sits between the user/keypad logic and hangy. It owns the start pulse, per-guess pacing, hit/miss detection and win/lose latching.
- Exactly one guess is in flight at a time. The core has no ready signal, so pacing is by fixed settle counts.

---
 rtl/hangy_pkg.sv | 34 +++
 rtl/hangy_player_if.sv | 33 +++
 rtl/hangy_strobe_gen.sv | 24 ++
 rtl/hangy_player.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hangy_pkg.sv
// Shared widths, chip_input codes and FSM state encoding for the hangy host-side player.
package hangy_pkg;

    localparam int LETTER_W   = 5;
    localparam int IN_W       = 6;
    localparam int OUT_W      = 7;

    localparam int STROBE_BIT = 5;
    localparam int WIN_BIT    = 5;
    localparam int LOSE_BIT   = 6;

    localparam logic [IN_W-1:0]     START_CODE   = 6'b111111;
    localparam logic [IN_W-1:0]     RESTART_CODE = 6'b100000;
    localparam logic [LETTER_W-1:0] LAST_LETTER  = 5'd25;

    typedef enum logic [2:0] {
        IDLE,
        START_WAIT,
        READY,
        SETTLE,
        EVAL,
        OVER,
        RESTART
    } player_state_t;

    function automatic logic [IN_W-1:0] guess_code(input logic [LETTER_W-1:0] letter);
        logic [IN_W-1:0] code;
        code             = '0;
        code[STROBE_BIT] = 1'b1;
        code[LETTER_W-1:0] = letter;
        return code;
    endfunction

endpackage

// File: rtl/hangy_player_if.sv
// Guess handshake and per-guess result bundle between the requester and hangy_player.
// dup_guess exists only when HANGY_PLAYER_DUP_FILTER_EN is defined.
interface hangy_player_if;
    import hangy_pkg::*;

    logic                guess_valid;
    logic                guess_ready;
    logic [LETTER_W-1:0] guess_letter;
    logic                result_valid;
    logic                result_hit;
    logic                result_invalid;
    logic [LETTER_W-1:0] result_mask;
`ifdef HANGY_PLAYER_DUP_FILTER_EN
    logic                dup_guess;
`endif

    modport master (
        output guess_valid, guess_letter,
        input  guess_ready, result_valid, result_hit, result_invalid, result_mask
`ifdef HANGY_PLAYER_DUP_FILTER_EN
        , input dup_guess
`endif
    );

    modport slave (
        input  guess_valid, guess_letter,
        output guess_ready, result_valid, result_hit, result_invalid, result_mask
`ifdef HANGY_PLAYER_DUP_FILTER_EN
        , output dup_guess
`endif
    );

endinterface

// File: rtl/hangy_strobe_gen.sv
// Registered chip_input driver: emits the requested code for one cycle, zero otherwise.
module hangy_strobe_gen
    import hangy_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic [IN_W-1:0] code,
    output logic [IN_W-1:0] chip_input
);

    logic [IN_W-1:0] chip_input_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chip_input_reg <= '0;
        end else begin
            chip_input_reg <= req ? code : '0;
        end
    end

    assign chip_input = chip_input_reg;

endmodule

// File: rtl/hangy_player.sv
// Host-side driver for the hangy core: paces one guess at a time and decodes hit/win/lose.
// Define HANGY_PLAYER_DUP_FILTER_EN to suppress letters already guessed in the current game.
module hangy_player
    import hangy_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int START_CYCLES  = 3,
    parameter int MAX_MISSES    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             new_game,
    hangy_player_if.slave    guess,
    output logic [IN_W-1:0]  chip_input,
    input  logic [OUT_W-1:0] chip_output,
    output logic [2:0]       misses,
    output logic             game_won,
    output logic             game_lost,
    output logic             busy
);

    localparam int CNT_MAX = (SETTLE_CYCLES > START_CYCLES) ? SETTLE_CYCLES : START_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    player_state_t       state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [LETTER_W-1:0] prev_mask_reg, prev_mask_next;
    logic [2:0]          misses_reg, misses_next;
    logic                won_reg, won_next;
    logic                lost_reg, lost_next;
    logic                result_valid_reg, result_valid_next;
    logic                result_hit_reg, result_hit_next;
    logic                result_invalid_reg, result_invalid_next;
    logic [LETTER_W-1:0] result_mask_reg, result_mask_next;
`ifdef HANGY_PLAYER_DUP_FILTER_EN
    logic [LAST_LETTER:0] guessed_set_reg, guessed_set_next;
    logic                 dup_guess_reg, dup_guess_next;
`endif

    logic            strobe_req;
    logic [IN_W-1:0] strobe_code;
    logic            hit;

    // A hit means the core revealed a position that was hidden before this guess.
    assign hit = |(chip_output[LETTER_W-1:0] & ~prev_mask_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg          <= IDLE;
            cnt_reg            <= '0;
            prev_mask_reg      <= '0;
            misses_reg         <= '0;
            won_reg            <= 1'b0;
            lost_reg           <= 1'b0;
            result_valid_reg   <= 1'b0;
            result_hit_reg     <= 1'b0;
            result_invalid_reg <= 1'b0;
            result_mask_reg    <= '0;
`ifdef HANGY_PLAYER_DUP_FILTER_EN
            guessed_set_reg    <= '0;
            dup_guess_reg      <= 1'b0;
`endif
        end else begin
            state_reg          <= state_next;
            cnt_reg            <= cnt_next;
            prev_mask_reg      <= prev_mask_next;
            misses_reg         <= misses_next;
            won_reg            <= won_next;
            lost_reg           <= lost_next;
            result_valid_reg   <= result_valid_next;
            result_hit_reg     <= result_hit_next;
            result_invalid_reg <= result_invalid_next;
            result_mask_reg    <= result_mask_next;
`ifdef HANGY_PLAYER_DUP_FILTER_EN
            guessed_set_reg    <= guessed_set_next;
            dup_guess_reg      <= dup_guess_next;
`endif
        end
    end

    always_comb begin
        state_next          = state_reg;
        cnt_next            = cnt_reg;
        prev_mask_next      = prev_mask_reg;
        misses_next         = misses_reg;
        won_next            = won_reg;
        lost_next           = lost_reg;
        result_valid_next   = 1'b0;
        result_hit_next     = 1'b0;
        result_invalid_next = 1'b0;
        result_mask_next    = result_mask_reg;
        strobe_req          = 1'b0;
        strobe_code         = '0;
`ifdef HANGY_PLAYER_DUP_FILTER_EN
        guessed_set_next    = guessed_set_reg;
        dup_guess_next      = 1'b0;
`endif

        case (state_reg)
            IDLE: begin
                if (new_game) begin
                    strobe_req  = 1'b1;
                    strobe_code = START_CODE;
                    cnt_next    = '0;
                    state_next  = START_WAIT;
                end
            end

            START_WAIT: begin
                prev_mask_next = '0;
                misses_next    = '0;
                won_next       = 1'b0;
                lost_next      = 1'b0;
`ifdef HANGY_PLAYER_DUP_FILTER_EN
                guessed_set_next = '0;
`endif
                if (cnt_reg == CNT_W'(START_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = READY;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            READY: begin
                if (guess.guess_valid) begin
                    if (guess.guess_letter > LAST_LETTER) begin
                        result_valid_next   = 1'b1;
                        result_invalid_next = 1'b1;
`ifdef HANGY_PLAYER_DUP_FILTER_EN
                    end else if (guessed_set_reg[guess.guess_letter]) begin
                        result_valid_next = 1'b1;
                        dup_guess_next    = 1'b1;
                        result_mask_next  = prev_mask_reg;
`endif
                    end else begin
                        strobe_req  = 1'b1;
                        strobe_code = guess_code(guess.guess_letter);
                        cnt_next    = '0;
                        state_next  = SETTLE;
`ifdef HANGY_PLAYER_DUP_FILTER_EN
                        guessed_set_next[guess.guess_letter] = 1'b1;
`endif
                    end
                end
            end

            // The core has no ready flag, so wait its worst-case evaluation time.
            SETTLE: begin
                if (cnt_reg == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = EVAL;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            EVAL: begin
                prev_mask_next    = prev_mask_reg | chip_output[LETTER_W-1:0];
                result_valid_next = 1'b1;
                result_hit_next   = hit;
                result_mask_next  = chip_output[LETTER_W-1:0];
                if (!hit && (misses_reg < 3'(MAX_MISSES))) begin
                    misses_next = misses_reg + 3'd1;
                end
                if (chip_output[WIN_BIT]) begin
                    won_next   = 1'b1;
                    state_next = OVER;
                end else if (chip_output[LOSE_BIT]) begin
                    lost_next  = 1'b1;
                    state_next = OVER;
                end else begin
                    state_next = READY;
                end
            end

            OVER: begin
                if (new_game) begin
                    strobe_req  = 1'b1;
                    strobe_code = RESTART_CODE;
                    cnt_next    = '0;
                    state_next  = RESTART;
                end
            end

            // One idle cycle between the return-to-init strobe and the start strobe.
            RESTART: begin
                if (cnt_reg == '0) begin
                    cnt_next = CNT_W'(1);
                end else begin
                    strobe_req  = 1'b1;
                    strobe_code = START_CODE;
                    cnt_next    = '0;
                    state_next  = START_WAIT;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    hangy_strobe_gen u_strobe_gen (
        .clk        (clk),
        .reset      (reset),
        .req        (strobe_req),
        .code       (strobe_code),
        .chip_input (chip_input)
    );

    assign guess.guess_ready    = (state_reg == READY);
    assign guess.result_valid   = result_valid_reg;
    assign guess.result_hit     = result_hit_reg;
    assign guess.result_invalid = result_invalid_reg;
    assign guess.result_mask    = result_mask_reg;
`ifdef HANGY_PLAYER_DUP_FILTER_EN
    assign guess.dup_guess      = dup_guess_reg;
`endif
    assign misses    = misses_reg;
    assign game_won  = won_reg;
    assign game_lost = lost_reg;
    assign busy      = (state_reg != READY) && (state_reg != IDLE);

endmodule
